// File: rtl/seq_monitor.sv
// seq_monitor
// Checks the output of the 4-bit skip-counter whose legal cycle is
// 0,1,2,3,5,7,8,9,0. After LOCK_LEN correct transitions in a row the
// monitor locks. From then on it flags every illegal value or wrong
// transition and counts completed 9->0 wraps.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, priority over all inputs
//   q_in       counter value under test
//   en         sample qualifier; q_in is ignored when low
//   clr_err    synchronous clear of err_cnt / err_sticky (a same-cycle error wins)
//   locked     high while in LOCK
//   err_pulse  one-cycle pulse per detected error
//   err_sticky set by any error, cleared by rst or clr_err
//   err_cnt    saturating error count
//   wrap_pulse one-cycle pulse per correct 9->0 while locked
//   wrap_cnt   completed wraps while locked, modulo 2^WRAP_W
// All outputs are registered and appear the cycle after the sampling edge.
module seq_monitor #(
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        q_in,
    input  logic              en,
    input  logic              clr_err,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    // Bit v set means value v is part of the legal cycle {0,1,2,3,5,7,8,9}.
    localparam logic [15:0] LEGAL_MASK = 16'b0000_0011_1010_1111;
    localparam logic [4:0]  LOCK_TGT   = 5'(LOCK_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          prev_reg, prev_next;
    logic [3:0]          good_cnt_reg, good_cnt_next;
    logic                locked_reg;
    logic                err_pulse_reg;
    logic                err_sticky_reg;
    logic [ERR_W-1:0]    err_cnt_reg;
    logic                wrap_pulse_reg;
    logic [WRAP_W-1:0]   wrap_cnt_reg;

    logic                err_ev;
    logic                wrap_ev;
    logic                q_legal;
    logic                q_match;
    logic [3:0]          nxt_val;
    logic [4:0]          good_inc;

    // Expected successor of the previous sample. prev is always a legal
    // value, so the default arm is never reached in operation.
    always_comb begin
        nxt_val = 4'd0;
        case (prev_reg)
            4'd0:    nxt_val = 4'd1;
            4'd1:    nxt_val = 4'd2;
            4'd2:    nxt_val = 4'd3;
            4'd3:    nxt_val = 4'd5;
            4'd5:    nxt_val = 4'd7;
            4'd7:    nxt_val = 4'd8;
            4'd8:    nxt_val = 4'd9;
            4'd9:    nxt_val = 4'd0;
            default: nxt_val = 4'd0;
        endcase
    end

    assign q_legal  = LEGAL_MASK[q_in];
    assign q_match  = (q_in == nxt_val);
    assign good_inc = {1'b0, good_cnt_reg} + 5'd1;

    always_comb begin
        state_next    = state_reg;
        prev_next     = prev_reg;
        good_cnt_next = good_cnt_reg;
        err_ev        = 1'b0;
        wrap_ev       = 1'b0;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    // No reference sample yet: a legal value just seeds prev.
                    if (q_legal) begin
                        prev_next     = q_in;
                        good_cnt_next = 4'd0;
                        state_next    = ACQ;
                    end else begin
                        err_ev = 1'b1;
                    end
                end
                ACQ: begin
                    if (q_match) begin
                        prev_next = q_in;
                        if (good_inc == LOCK_TGT) begin
                            state_next    = LOCK;
                            good_cnt_next = 4'd0;
                        end else begin
                            good_cnt_next = good_inc[3:0];
                        end
                    end else begin
                        err_ev        = 1'b1;
                        good_cnt_next = 4'd0;
                        if (q_legal) begin
                            prev_next = q_in;      // reseed from the wrong-but-legal value
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                LOCK: begin
                    if (q_match) begin
                        prev_next = q_in;
                        wrap_ev   = (prev_reg == 4'd9);
                    end else begin
                        err_ev = 1'b1;
                        if (q_legal) begin
                            prev_next     = q_in;
                            good_cnt_next = 4'd0;
                            state_next    = ACQ;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            prev_reg       <= 4'd0;
            good_cnt_reg   <= 4'd0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_cnt_reg    <= '0;
            wrap_pulse_reg <= 1'b0;
            wrap_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            good_cnt_reg   <= good_cnt_next;
            locked_reg     <= (state_next == LOCK);
            err_pulse_reg  <= err_ev;
            wrap_pulse_reg <= wrap_ev;
            if (wrap_ev) begin
                wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
            end
            // An error in the same cycle as clr_err wins: the count restarts at 1.
            if (err_ev) begin
                err_sticky_reg <= 1'b1;
                if (clr_err) begin
                    err_cnt_reg <= ERR_W'(1);
                end else if (err_cnt_reg != {ERR_W{1'b1}}) begin
                    err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                end
            end else if (clr_err) begin
                err_sticky_reg <= 1'b0;
                err_cnt_reg    <= '0;
            end
        end
    end

    assign locked     = locked_reg;
    assign err_pulse  = err_pulse_reg;
    assign err_sticky = err_sticky_reg;
    assign err_cnt    = err_cnt_reg;
    assign wrap_pulse = wrap_pulse_reg;
    assign wrap_cnt   = wrap_cnt_reg;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor. Every step pushes the expected outputs
// from a behavioural model onto a queue; after the clock edge the entry
// is popped and compared with the DUT. Extra constant checks pin down
// the key scenarios independently of the model.
module tb_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q_in;
    logic       en;
    logic       clr_err;
    logic       locked;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_cnt;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_monitor #(.LOCK_LEN(4), .ERR_W(8), .WRAP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .en         (en),
        .clr_err    (clr_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt)
    );

    typedef struct {
        logic       locked;
        logic       err_pulse;
        logic       err_sticky;
        logic [7:0] err_cnt;
        logic       wrap_pulse;
        logic [7:0] wrap_cnt;
    } exp_t;

    exp_t sb[$];

    // Model state: 0=IDLE, 1=ACQ, 2=LOCK
    int         m_state = 0;
    logic [3:0] m_prev  = 4'd0;
    int         m_good  = 0;
    logic [7:0] m_errc  = 8'd0;
    logic       m_stky  = 1'b0;
    logic [7:0] m_wrapc = 8'd0;

    function automatic int seq_idx(input logic [3:0] v);
        logic [3:0] cyc [8];
        cyc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9};
        for (int i = 0; i < 8; i++) if (cyc[i] == v) return i;
        return -1;
    endfunction

    function automatic logic [3:0] seq_next(input logic [3:0] v);
        logic [3:0] cyc [8];
        cyc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9};
        return cyc[(seq_idx(v) + 1) % 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, push expectation,
    // then pop and compare after the edge.
    task automatic step(input logic e, input logic [3:0] v, input logic c, input logic r);
        exp_t x;
        exp_t got;
        logic err;
        logic wrp;
        rst = r; en = e; q_in = v; clr_err = c;
        err = 1'b0;
        wrp = 1'b0;
        if (r) begin
            m_state = 0; m_prev = 4'd0; m_good = 0;
            m_errc = 8'd0; m_stky = 1'b0; m_wrapc = 8'd0;
        end else begin
            if (e) begin
                if (m_state == 0) begin
                    if (seq_idx(v) >= 0) begin m_prev = v; m_good = 0; m_state = 1; end
                    else err = 1'b1;
                end else if (m_state == 1) begin
                    if (v == seq_next(m_prev)) begin
                        m_prev = v;
                        m_good = m_good + 1;
                        if (m_good == 4) begin m_state = 2; m_good = 0; end
                    end else begin
                        err = 1'b1; m_good = 0;
                        if (seq_idx(v) >= 0) m_prev = v; else m_state = 0;
                    end
                end else begin
                    if (v == seq_next(m_prev)) begin
                        if (m_prev == 4'd9) begin wrp = 1'b1; m_wrapc = m_wrapc + 8'd1; end
                        m_prev = v;
                    end else begin
                        err = 1'b1;
                        if (seq_idx(v) >= 0) begin m_prev = v; m_good = 0; m_state = 1; end
                        else m_state = 0;
                    end
                end
            end
            if (err) begin
                m_stky = 1'b1;
                if (c) m_errc = 8'd1;
                else if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
            end else if (c) begin
                m_stky = 1'b0; m_errc = 8'd0;
            end
        end
        x.locked = (m_state == 2) && !r;
        x.err_pulse = err;
        x.err_sticky = m_stky;
        x.err_cnt = m_errc;
        x.wrap_pulse = wrp;
        x.wrap_cnt = m_wrapc;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("locked", locked, got.locked);
        chk("err_pulse", err_pulse, got.err_pulse);
        chk("err_sticky", err_sticky, got.err_sticky);
        chk("err_cnt", err_cnt, got.err_cnt);
        chk("wrap_pulse", wrap_pulse, got.wrap_pulse);
        chk("wrap_cnt", wrap_cnt, got.wrap_cnt);
    endtask

    task automatic s(input logic [3:0] v);
        step(1'b1, v, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] cyc8 [8];
        cyc8 = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
        rst = 1'b1; en = 1'b0; q_in = 4'd0; clr_err = 1'b0;

        // Reset
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd4, 1'b1, 1'b1);
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_wrap_cnt", wrap_cnt, 0);

        // Acquire lock: 0,1,2,3 then 5
        s(4'd0); chk("acq0_locked", locked, 0);
        s(4'd1); s(4'd2);
        s(4'd3); chk("acq3_locked", locked, 0);
        s(4'd5); chk("lock_after5", locked, 1);
        chk("lock_err_cnt", err_cnt, 0);

        // First wrap
        s(4'd7); s(4'd8); s(4'd9);
        s(4'd0); chk("wrap_pulse_hi", wrap_pulse, 1); chk("wrap_cnt_1", wrap_cnt, 1);
        s(4'd1); chk("wrap_pulse_lo", wrap_pulse, 0);

        // 256 full cycles -> wrap_cnt back to 1
        for (int n = 0; n < 256; n++)
            for (int k = 0; k < 8; k++) s(cyc8[k]);
        chk("wrap_cnt_modulo", wrap_cnt, 1);
        chk("wrap_no_err", err_cnt, 0);

        // Illegal value 4 while locked at prev=3
        s(4'd2); s(4'd3);
        s(4'd4);
        chk("ill_err_pulse", err_pulse, 1); chk("ill_sticky", err_sticky, 1);
        chk("ill_err_cnt", err_cnt, 1); chk("ill_locked", locked, 0);
        s(4'd5); chk("reseed_no_err", err_pulse, 0);
        s(4'd7); s(4'd8); s(4'd9);
        s(4'd0); chk("relock_a", locked, 1); chk("acq_wrap_ignored", wrap_cnt, 1);

        // Legal wrong value 8 while locked at prev=5
        s(4'd1); s(4'd2); s(4'd3); s(4'd5);
        s(4'd8); chk("wrong_err_cnt", err_cnt, 2); chk("wrong_locked", locked, 0);
        s(4'd9); s(4'd0); s(4'd1);
        s(4'd2); chk("relock_b", locked, 1); chk("acq_wrap_ignored_b", wrap_cnt, 1);

        // en gating with garbage, then repeated value
        step(1'b0, 4'd4, 1'b0, 1'b0);
        step(1'b0, 4'd15, 1'b0, 1'b0);
        s(4'd3); chk("en_gap_no_err", err_pulse, 0); chk("en_gap_locked", locked, 1);
        s(4'd3); chk("repeat_err", err_pulse, 1); chk("repeat_err_cnt", err_cnt, 3);

        // Saturation
        for (int n = 0; n < 300; n++) s(4'd3);
        chk("err_saturated", err_cnt, 255);

        // clr_err alone, then clr_err together with an error
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("clr_cnt", err_cnt, 0); chk("clr_sticky", err_sticky, 0);
        step(1'b1, 4'd3, 1'b1, 1'b0);
        chk("clr_err_win_cnt", err_cnt, 1); chk("clr_err_win_sticky", err_sticky, 1);
        chk("clr_err_win_pulse", err_pulse, 1);

        // Reset while locked; first sample afterwards is only a seed
        s(4'd5); s(4'd7); s(4'd8);
        s(4'd9); chk("pre_rst_locked", locked, 1);
        step(1'b1, 4'd0, 1'b0, 1'b1);
        chk("mid_rst_locked", locked, 0);
        s(4'd0);
        chk("seed_no_err", err_pulse, 0); chk("seed_no_wrap", wrap_pulse, 0);
        chk("seed_wrap_cnt", wrap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
